// File: rtl/tl_ram_responder.sv
// ---------------------------------------------------------------------------
// tl_ram_responder
//
// TileLink-UL manager that terminates an A/D channel pair in front of a
// 64-bit-wide register-array RAM. It serves Get, PutFullData and
// PutPartialData, including multi-beat bursts. Responses leave through a
// single registered D stage.
//
// Parameters
//   BASE_ADDR    byte address of RAM word 0
//   DEPTH_WORDS  number of 64-bit words (power of two)
//   MAX_SIZE     largest lg2(bytes) accepted without a denied response
//
// Ports
//   clock / reset              rising-edge clock, async active-high reset
//   auto_in_a_*                A channel request (opcode/size/source/addr/
//                              mask/data/corrupt, param ignored)
//   auto_in_d_*                D channel response (registered)
//   err_opcode                 sticky flag: an unsupported opcode was seen
//
// Optional feature (macro TL_RAM_PERF_EN)
//   perf_get_count             completed non-denied Gets (saturating)
//   perf_put_count             acknowledged non-denied Puts (saturating)
// ---------------------------------------------------------------------------
module tl_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned MAX_SIZE    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [4:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [4:0]  auto_in_d_bits_source,
    output logic [2:0]  auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt,
    output logic        err_opcode
`ifdef TL_RAM_PERF_EN
    ,
    output logic [31:0] perf_get_count,
    output logic [31:0] perf_put_count
`endif
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W      = 12;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 8);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {IDLE, GET, PUT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   last_q;
    logic [IDX_W-1:0]   base_q;
    logic               denied_q;
    logic [4:0]         src_q;
    logic [3:0]         size_q;

    logic               d_valid_q;
    logic [2:0]         d_opcode_q;
    logic [3:0]         d_size_q;
    logic [4:0]         d_source_q;
    logic               d_denied_q;
    logic [63:0]        d_data_q;
    logic               d_corrupt_q;
    logic               err_q;

    logic [63:0]        mem [DEPTH_WORDS];

    logic               a_fire;
    logic               d_fire;
    logic [31:0]        req_off;
    logic               req_denied;
    logic               req_known;
    logic               req_is_put;
    logic [CNT_W-1:0]   req_last;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               unused_ok;

    assign auto_in_a_ready = (state_q != GET) && (!d_valid_q || auto_in_d_ready);
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;
    assign d_fire          = d_valid_q && auto_in_d_ready;

    // Decode of the request presented on A. An address below the base wraps
    // to a huge offset in the unsigned subtract and so lands out of range.
    always_comb begin
        req_off    = auto_in_a_bits_address - BASE_ADDR;
        req_denied = (req_off >= SPAN_BYTES) || (auto_in_a_bits_size > 4'(MAX_SIZE));
        req_is_put = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                     (auto_in_a_bits_opcode == OP_PUT_PART);
        req_known  = req_is_put || (auto_in_a_bits_opcode == OP_GET);
        req_last   = '0;
        if (auto_in_a_bits_size > 4'd3) begin
            req_last = (CNT_W'(1) << (auto_in_a_bits_size - 4'd3)) - CNT_W'(1);
        end
        req_idx  = req_off[IDX_W+2:3] & ~IDX_W'(req_last);
        next_idx = base_q + IDX_W'(cnt_q + CNT_W'(1));
    end

    // A Put beat writes at the edge it fires; the first beat addresses from
    // the live A bits, later burst beats from the latched base plus counter.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = req_idx;
        if (a_fire && !auto_in_a_bits_corrupt) begin
            if (state_q == IDLE && req_is_put && !req_denied) begin
                wr_en = 1'b1;
            end else if (state_q == PUT && !denied_q) begin
                wr_en  = 1'b1;
                wr_idx = base_q + IDX_W'(cnt_q);
            end
        end
    end

    // RAM array: intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= auto_in_a_bits_data[b*8 +: 8];
                end
            end
        end
    end

    // Transaction FSM and the registered D stage. In GET, cnt_q is the beat
    // currently held in D; in PUT it is the next beat expected on A. A D fire
    // clears d_valid first so that a same-edge reload replaces the drained
    // response without a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            base_q      <= '0;
            denied_q    <= 1'b0;
            src_q       <= '0;
            size_q      <= '0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_data_q    <= '0;
            d_corrupt_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (d_fire) begin
                        d_valid_q <= 1'b0;
                    end
                    if (a_fire) begin
                        src_q    <= auto_in_a_bits_source;
                        size_q   <= auto_in_a_bits_size;
                        base_q   <= req_idx;
                        last_q   <= req_last;
                        denied_q <= req_denied;
                        if (!req_known) begin
                            err_q       <= 1'b1;
                            d_valid_q   <= 1'b1;
                            d_opcode_q  <= OP_ACK;
                            d_size_q    <= auto_in_a_bits_size;
                            d_source_q  <= auto_in_a_bits_source;
                            d_denied_q  <= 1'b1;
                            d_data_q    <= '0;
                            d_corrupt_q <= 1'b0;
                        end else if (!req_is_put) begin
                            state_q     <= GET;
                            cnt_q       <= '0;
                            d_valid_q   <= 1'b1;
                            d_opcode_q  <= OP_ACK_DATA;
                            d_size_q    <= auto_in_a_bits_size;
                            d_source_q  <= auto_in_a_bits_source;
                            d_denied_q  <= req_denied;
                            d_data_q    <= req_denied ? 64'd0 : mem[req_idx];
                            d_corrupt_q <= req_denied;
                        end else if (req_last == '0) begin
                            d_valid_q   <= 1'b1;
                            d_opcode_q  <= OP_ACK;
                            d_size_q    <= auto_in_a_bits_size;
                            d_source_q  <= auto_in_a_bits_source;
                            d_denied_q  <= req_denied;
                            d_data_q    <= '0;
                            d_corrupt_q <= 1'b0;
                        end else begin
                            state_q <= PUT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                GET: begin
                    if (d_fire) begin
                        if (cnt_q == last_q) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            d_valid_q <= 1'b0;
                        end else begin
                            cnt_q    <= cnt_q + CNT_W'(1);
                            d_data_q <= denied_q ? 64'd0 : mem[next_idx];
                        end
                    end
                end
                PUT: begin
                    if (d_fire) begin
                        d_valid_q <= 1'b0;
                    end
                    if (a_fire) begin
                        if (cnt_q == last_q) begin
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            d_valid_q   <= 1'b1;
                            d_opcode_q  <= OP_ACK;
                            d_size_q    <= size_q;
                            d_source_q  <= src_q;
                            d_denied_q  <= denied_q;
                            d_data_q    <= '0;
                            d_corrupt_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode_q;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size_q;
    assign auto_in_d_bits_source  = d_source_q;
    assign auto_in_d_bits_sink    = 3'd0;
    assign auto_in_d_bits_denied  = d_denied_q;
    assign auto_in_d_bits_data    = d_data_q;
    assign auto_in_d_bits_corrupt = d_corrupt_q;
    assign err_opcode             = err_q;

    assign unused_ok = ^{auto_in_a_bits_param, req_off[2:0], req_off[31:IDX_W+3]};

`ifdef TL_RAM_PERF_EN
    // Only Put acks are non-denied AccessAcks, so the D register alone tells
    // which drained response was a successful Put.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_get_count <= '0;
            perf_put_count <= '0;
        end else begin
            if (d_fire && state_q == GET && cnt_q == last_q && !denied_q &&
                perf_get_count != 32'hFFFF_FFFF) begin
                perf_get_count <= perf_get_count + 32'd1;
            end
            if (d_fire && d_opcode_q == OP_ACK && !d_denied_q &&
                perf_put_count != 32'hFFFF_FFFF) begin
                perf_put_count <= perf_put_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tl_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_tl_ram_responder
//
// Directed bench for tl_ram_responder: single-beat Put/Get, partial writes,
// 8-beat bursts with D back-pressure, denied requests, unsupported opcode,
// back-to-back response replacement and asynchronous reset mid-burst.
// ---------------------------------------------------------------------------
module tb_tl_ram_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        aValid = 1'b0;
    logic        aReady;
    logic [2:0]  aOpcode = '0;
    logic [2:0]  aParam = '0;
    logic [3:0]  aSize = '0;
    logic [4:0]  aSource = '0;
    logic [31:0] aAddress = '0;
    logic [7:0]  aMask = '0;
    logic [63:0] aData = '0;
    logic        aCorrupt = 1'b0;
    logic        dReady = 1'b0;
    logic        dValid;
    logic [2:0]  dOpcode;
    logic [1:0]  dParam;
    logic [3:0]  dSize;
    logic [4:0]  dSource;
    logic [2:0]  dSink;
    logic        dDenied;
    logic [63:0] dData;
    logic        dCorrupt;
    logic        errOpcode;

    int totalChecks = 0;
    int badChecks   = 0;

    tl_ram_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_valid        (aValid),
        .auto_in_a_ready        (aReady),
        .auto_in_a_bits_opcode  (aOpcode),
        .auto_in_a_bits_param   (aParam),
        .auto_in_a_bits_size    (aSize),
        .auto_in_a_bits_source  (aSource),
        .auto_in_a_bits_address (aAddress),
        .auto_in_a_bits_mask    (aMask),
        .auto_in_a_bits_data    (aData),
        .auto_in_a_bits_corrupt (aCorrupt),
        .auto_in_d_ready        (dReady),
        .auto_in_d_valid        (dValid),
        .auto_in_d_bits_opcode  (dOpcode),
        .auto_in_d_bits_param   (dParam),
        .auto_in_d_bits_size    (dSize),
        .auto_in_d_bits_source  (dSource),
        .auto_in_d_bits_sink    (dSink),
        .auto_in_d_bits_denied  (dDenied),
        .auto_in_d_bits_data    (dData),
        .auto_in_d_bits_corrupt (dCorrupt),
        .err_opcode             (errOpcode)
    );

    // 100 MHz free-running clock.
    always #5 clock = ~clock;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one A beat and hold it until it fires; returns #1 after the
    // firing edge so registered responses are already visible.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] sz, input logic [4:0] src,
                                 input logic [31:0] addr, input logic [7:0] mask,
                                 input logic [63:0] data, input logic corrupt);
        int waitCnt;
        waitCnt  = 0;
        aValid   = 1'b1;
        aOpcode  = op;
        aSize    = sz;
        aSource  = src;
        aAddress = addr;
        aMask    = mask;
        aData    = data;
        aCorrupt = corrupt;
        while (!aReady && waitCnt < 200) begin
            @(posedge clock); #1;
            waitCnt++;
        end
        if (!aReady) begin
            checkOutput("a_ready timeout", 64'(aReady), 64'd1);
        end
        @(posedge clock); #1;
        aValid = 1'b0;
    endtask

    // Check the response held in D, then drain it with a one-cycle d_ready.
    task automatic expectResp(input string tag, input logic [2:0] op, input logic [4:0] src,
                              input logic denied, input logic [63:0] data, input logic corrupt);
        checkOutput({tag, " valid"},   64'(dValid),   64'd1);
        checkOutput({tag, " opcode"},  64'(dOpcode),  64'(op));
        checkOutput({tag, " source"},  64'(dSource),  64'(src));
        checkOutput({tag, " denied"},  64'(dDenied),  64'(denied));
        checkOutput({tag, " data"},    dData,         data);
        checkOutput({tag, " corrupt"}, 64'(dCorrupt), 64'(corrupt));
        dReady = 1'b1;
        @(posedge clock); #1;
        dReady = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset d_valid", 64'(dValid), 64'd0);
        checkOutput("reset err_opcode", 64'(errOpcode), 64'd0);
        checkOutput("reset d_data", dData, 64'd0);
        checkOutput("reset d_source", 64'(dSource), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("idle a_ready", 64'(aReady), 64'd1);

        // Single-beat PutFull then Get of the same word.
        applyStimulus(3'd0, 4'd3, 5'd5, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0);
        expectResp("putfull ack", 3'd0, 5'd5, 1'b0, 64'd0, 1'b0);
        applyStimulus(3'd4, 4'd3, 5'd6, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        checkOutput("get a_ready held low", 64'(aReady), 64'd0);
        expectResp("get full", 3'd1, 5'd6, 1'b0, 64'h1122334455667788, 1'b0);
        checkOutput("get drained", 64'(dValid), 64'd0);

        // PutPartial on the low four lanes.
        applyStimulus(3'd1, 4'd3, 5'd7, 32'h8000_0010, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 1'b0);
        expectResp("putpartial ack", 3'd0, 5'd7, 1'b0, 64'd0, 1'b0);
        applyStimulus(3'd4, 4'd3, 5'd8, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        expectResp("get partial", 3'd1, 5'd8, 1'b0, 64'h11223344AAAABBBB, 1'b0);

        // Corrupt beat must not write.
        applyStimulus(3'd0, 4'd3, 5'd9, 32'h8000_0010, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        expectResp("corrupt put ack", 3'd0, 5'd9, 1'b0, 64'd0, 1'b0);
        applyStimulus(3'd4, 4'd3, 5'd9, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        expectResp("get after corrupt", 3'd1, 5'd9, 1'b0, 64'h11223344AAAABBBB, 1'b0);

        // 8-beat Put burst, data = beat index.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'd0, 4'd6, 5'd3, 32'h8000_0040, 8'hFF, 64'(i), 1'b0);
            if (i < 7) checkOutput("burst put no early ack", 64'(dValid), 64'd0);
        end
        expectResp("burst put ack", 3'd0, 5'd3, 1'b0, 64'd0, 1'b0);

        // 8-beat Get burst with d_ready alternating 0/1.
        applyStimulus(3'd4, 4'd6, 5'd4, 32'h8000_0040, 8'hFF, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("burst get valid", 64'(dValid), 64'd1);
            checkOutput("burst get data", dData, 64'(i));
            checkOutput("burst get a_ready", 64'(aReady), 64'd0);
            dReady = 1'b0;
            @(posedge clock); #1;
            checkOutput("burst get stall data", dData, 64'(i));
            checkOutput("burst get stall source", 64'(dSource), 64'd4);
            dReady = 1'b1;
            @(posedge clock); #1;
        end
        dReady = 1'b0;
        checkOutput("burst get done valid", 64'(dValid), 64'd0);
        checkOutput("burst get done a_ready", 64'(aReady), 64'd1);

        // Out-of-range Get and oversized Put are denied.
        applyStimulus(3'd4, 4'd3, 5'd10, 32'h8000_1000, 8'hFF, 64'd0, 1'b0);
        expectResp("denied get", 3'd1, 5'd10, 1'b1, 64'd0, 1'b1);
        checkOutput("denied get single beat", 64'(dValid), 64'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(3'd0, 4'd7, 5'd11, 32'h8000_0040, 8'hFF, 64'hDEAD_0000, 1'b0);
            if (i < 15) checkOutput("size7 put no early ack", 64'(dValid), 64'd0);
        end
        expectResp("size7 put ack", 3'd0, 5'd11, 1'b1, 64'd0, 1'b0);
        applyStimulus(3'd4, 4'd3, 5'd12, 32'h8000_0048, 8'hFF, 64'd0, 1'b0);
        expectResp("ram unchanged", 3'd1, 5'd12, 1'b0, 64'd1, 1'b0);

        // Below-base address underflows and is denied.
        applyStimulus(3'd4, 4'd3, 5'd13, 32'h7FFF_FFF8, 8'hFF, 64'd0, 1'b0);
        expectResp("below base get", 3'd1, 5'd13, 1'b1, 64'd0, 1'b1);

        // Ack still in D while the next Put fires: replaced with no bubble,
        // and a Get right after observes the fresh word.
        applyStimulus(3'd0, 4'd3, 5'd1, 32'h8000_0100, 8'hFF, 64'hAAAA_0000_0000_0001, 1'b0);
        dReady = 1'b1;
        applyStimulus(3'd0, 4'd3, 5'd2, 32'h8000_0108, 8'hFF, 64'hBBBB_0000_0000_0002, 1'b0);
        checkOutput("replace ack valid", 64'(dValid), 64'd1);
        checkOutput("replace ack source", 64'(dSource), 64'd2);
        applyStimulus(3'd4, 4'd3, 5'd14, 32'h8000_0108, 8'hFF, 64'd0, 1'b0);
        dReady = 1'b0;
        expectResp("read after write", 3'd1, 5'd14, 1'b0, 64'hBBBB_0000_0000_0002, 1'b0);

        // Unsupported opcode: sticky error, denied ack.
        applyStimulus(3'd2, 4'd3, 5'd15, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        checkOutput("bad opcode err", 64'(errOpcode), 64'd1);
        expectResp("bad opcode ack", 3'd0, 5'd15, 1'b1, 64'd0, 1'b0);
        applyStimulus(3'd4, 4'd3, 5'd16, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        expectResp("get after bad op", 3'd1, 5'd16, 1'b0, 64'h11223344AAAABBBB, 1'b0);
        checkOutput("err sticky", 64'(errOpcode), 64'd1);

        // Reset asserted while beat 3 of a Get burst sits in D.
        applyStimulus(3'd4, 4'd6, 5'd17, 32'h8000_0040, 8'hFF, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("pre-reset beat", dData, 64'(i));
            dReady = 1'b1;
            @(posedge clock); #1;
            dReady = 1'b0;
        end
        checkOutput("pre-reset beat3", dData, 64'd3);
        reset = 1'b1;
        #1;
        checkOutput("async reset d_valid", 64'(dValid), 64'd0);
        checkOutput("async reset a_ready", 64'(aReady), 64'd1);
        checkOutput("async reset err", 64'(errOpcode), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        applyStimulus(3'd4, 4'd3, 5'd18, 32'h8000_0058, 8'hFF, 64'd0, 1'b0);
        expectResp("post-reset get", 3'd1, 5'd18, 1'b0, 64'd3, 1'b0);
        checkOutput("post-reset idle", 64'(dValid), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
